// File: rtl/ch_pkg.sv
// Shared constants, types and pointer helper for the channel entry pool.
package ch_pkg;

  localparam int unsigned ENTRY_NUM = 5;
  localparam int unsigned PTR_W     = 3;
  localparam int unsigned PTR_SLOTS = 2 ** PTR_W;

  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [ENTRY_NUM-1:0] entry_vec_t;

  // Advance an entry index with wrap at ENTRY_NUM; out-of-range input folds to 0.
  function automatic ptr_t ptr_inc_mod(input ptr_t p);
    if (p >= PTR_W'(ENTRY_NUM - 1)) begin
      return '0;
    end
    return ptr_t'(p + PTR_W'(1));
  endfunction

endpackage

// File: rtl/ch_first_free.sv
// Round-robin first-free search: first set bit of free_i at or after start_ptr_i, with wrap.
module ch_first_free
  import ch_pkg::*;
(
  input  entry_vec_t free_i,
  input  ptr_t       start_ptr_i,
  output ptr_t       first_ptr_o
);

  logic [PTR_SLOTS-1:0] free_ext;
  ptr_t                 idx;
  logic                 found;

  // Zero-extend so every ptr_t value indexes a defined bit.
  assign free_ext = PTR_SLOTS'(free_i);

  always_comb begin
    first_ptr_o = start_ptr_i;
    found       = 1'b0;
    idx         = start_ptr_i;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!found && free_ext[idx]) begin
        first_ptr_o = idx;
        found       = 1'b1;
      end
      idx = ptr_inc_mod(idx);
    end
  end

endmodule

// File: rtl/ch_entry_alloc.sv
// Writer-side entry pool: allocates the first free entry from a round-robin pointer,
// exposes valid bits and a read port, and accepts per-index releases from the reader.
module ch_entry_alloc
  import ch_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output ptr_t              wr_ptr_o,
  output entry_vec_t        entry_valid_o,
  input  ptr_t              rd_ptr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              free_valid_i,
  input  ptr_t              free_ptr_i,
  output ptr_t              count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  entry_vec_t           entry_valid_q, entry_valid_d;
  ptr_t                 alloc_ptr_q, alloc_ptr_d;
  ptr_t                 count_q, count_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    data_q [ENTRY_NUM];
  logic [PTR_SLOTS-1:0] valid_ext;
  logic                 alloc_fire;
  logic                 free_legal;

  ch_first_free u_first_free (
    .free_i      (~entry_valid_q),
    .start_ptr_i (alloc_ptr_q),
    .first_ptr_o (wr_ptr_o)
  );

  assign full_o     = (count_q == PTR_W'(ENTRY_NUM));
  assign empty_o    = (count_q == '0);
  assign wr_ready_o = ~full_o;
  assign alloc_fire = wr_valid_i & wr_ready_o;

  // Out-of-range release indices land on the zero-extended bits and read as invalid.
  assign valid_ext  = PTR_SLOTS'(entry_valid_q);
  assign free_legal = free_valid_i & valid_ext[free_ptr_i];

  always_comb begin
    entry_valid_d = entry_valid_q;
    alloc_ptr_d   = alloc_ptr_q;
    count_d       = count_q;
    err_d         = err_q;
    if (free_valid_i && !free_legal) begin
      err_d = 1'b1;
    end
    for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
      if (free_legal && free_ptr_i == PTR_W'(k)) begin
        entry_valid_d[k] = 1'b0;
      end
      if (alloc_fire && wr_ptr_o == PTR_W'(k)) begin
        entry_valid_d[k] = 1'b1;
      end
    end
    if (alloc_fire) begin
      alloc_ptr_d = ptr_inc_mod(wr_ptr_o);
    end
    if (alloc_fire && !free_legal) begin
      count_d = ptr_t'(count_q + PTR_W'(1));
    end else if (!alloc_fire && free_legal) begin
      count_d = ptr_t'(count_q - PTR_W'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_valid_q <= '0;
      alloc_ptr_q   <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      entry_valid_q <= entry_valid_d;
      alloc_ptr_q   <= alloc_ptr_d;
      count_q       <= count_d;
      err_q         <= err_d;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
      if (alloc_fire && wr_ptr_o == PTR_W'(k)) begin
        data_q[k] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned k = 0; k < ENTRY_NUM; k++) begin
      if (rd_ptr_i == PTR_W'(k)) begin
        rd_data_o = data_q[k];
      end
    end
  end

  assign entry_valid_o = entry_valid_q;
  assign count_o       = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ch_entry_alloc.sv
// Directed bench for ch_entry_alloc with hand-computed expectations.
module tb_ch_entry_alloc;
  import ch_pkg::*;

  localparam int unsigned DATA_W = 32;

  logic              clk_i;
  logic              rst_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [DATA_W-1:0] wr_data_i;
  ptr_t              wr_ptr_o;
  entry_vec_t        entry_valid_o;
  ptr_t              rd_ptr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              free_valid_i;
  ptr_t              free_ptr_i;
  ptr_t              count_o;
  logic              full_o;
  logic              empty_o;
  logic              err_o;

  int unsigned n_checks;
  int unsigned n_errors;

  ch_entry_alloc #(.DATA_W(DATA_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_data_i     (wr_data_i),
    .wr_ptr_o      (wr_ptr_o),
    .entry_valid_o (entry_valid_o),
    .rd_ptr_i      (rd_ptr_i),
    .rd_data_o     (rd_data_o),
    .free_valid_i  (free_valid_i),
    .free_ptr_i    (free_ptr_i),
    .count_o       (count_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .err_o         (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_valid_i   = 1'b0;
    free_valid_i = 1'b0;
  endtask

  // Single write; checks the combinational slot choice before the edge.
  task automatic write(input logic [31:0] data, input ptr_t exp_ptr, input string tag);
    wr_valid_i = 1'b1;
    wr_data_i  = data;
    #1;
    check(tag, 32'(wr_ptr_o), 32'(exp_ptr));
    cyc();
    wr_valid_i = 1'b0;
  endtask

  task automatic release_idx(input ptr_t p);
    free_valid_i = 1'b1;
    free_ptr_i   = p;
    cyc();
    free_valid_i = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_i      = 1'b1;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    rd_ptr_i   = '0;
    free_valid_i = 1'b0;
    free_ptr_i = '0;
    #12;
    check("rst_valid", 32'(entry_valid_o), 32'h0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    check("rst_ready", 32'(wr_ready_o), 32'd1);
    check("rst_full",  32'(full_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    rst_i = 1'b0;

    // 1: fill from reset
    for (int i = 0; i < 5; i++) begin
      write(32'hA0 + 32'(i), PTR_W'(i), "t1_wr_ptr");
    end
    check("t1_valid", 32'(entry_valid_o), 32'h1F);
    check("t1_count", 32'(count_o), 32'd5);
    check("t1_full",  32'(full_o), 32'd1);
    check("t1_ready", 32'(wr_ready_o), 32'd0);
    check("t1_empty", 32'(empty_o), 32'd0);
    rd_ptr_i = 3'd3;
    #1;
    check("t1_rd3", rd_data_o, 32'hA3);

    // 2: release 2 from full, refill
    free_valid_i = 1'b1;
    free_ptr_i   = 3'd2;
    #1;
    check("t2_ready_same", 32'(wr_ready_o), 32'd0);
    cyc();
    free_valid_i = 1'b0;
    check("t2_ready_next", 32'(wr_ready_o), 32'd1);
    check("t2_valid", 32'(entry_valid_o), 32'h1B);
    check("t2_count", 32'(count_o), 32'd4);
    write(32'hB0, 3'd2, "t2_wr_ptr");
    rd_ptr_i = 3'd2;
    #1;
    check("t2_rd2", rd_data_o, 32'hB0);
    check("t2_alloc_ptr", 32'(dut.alloc_ptr_q), 32'd3);
    check("t2_full", 32'(full_o), 32'd1);

    // 3: wrap search
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      write(32'hC0 + 32'(i), PTR_W'(i), "t3_fill_ptr");
    end
    release_idx(3'd2);
    release_idx(3'd3);
    check("t3_valid_pre", 32'(entry_valid_o), 32'h03);
    check("t3_alloc_pre", 32'(dut.alloc_ptr_q), 32'd4);
    write(32'hD4, 3'd4, "t3_wr_ptr4");
    check("t3_alloc_mid", 32'(dut.alloc_ptr_q), 32'd0);
    write(32'hD2, 3'd2, "t3_wr_ptr2");
    check("t3_alloc_post", 32'(dut.alloc_ptr_q), 32'd3);
    check("t3_valid_post", 32'(entry_valid_o), 32'h17);
    rd_ptr_i = 3'd4;
    #1;
    check("t3_rd4", rd_data_o, 32'hD4);

    // 4: simultaneous write and release
    release_idx(3'd4);
    check("t4_count_pre", 32'(count_o), 32'd3);
    check("t4_valid_pre", 32'(entry_valid_o), 32'h07);
    wr_valid_i   = 1'b1;
    wr_data_i    = 32'hE3;
    free_valid_i = 1'b1;
    free_ptr_i   = 3'd0;
    #1;
    check("t4_wr_ptr", 32'(wr_ptr_o), 32'd3);
    cyc();
    idle();
    check("t4_count", 32'(count_o), 32'd3);
    check("t4_valid", 32'(entry_valid_o), 32'h0E);
    check("t4_err", 32'(err_o), 32'd0);

    // 5: illegal releases
    pulse_reset();
    write(32'hF0, 3'd0, "t5_wr_ptr");
    release_idx(3'd1);
    check("t5_valid_inv", 32'(entry_valid_o), 32'h01);
    check("t5_err_inv", 32'(err_o), 32'd1);
    release_idx(3'd6);
    check("t5_valid_oor", 32'(entry_valid_o), 32'h01);
    check("t5_count_oor", 32'(count_o), 32'd1);
    check("t5_err_oor", 32'(err_o), 32'd1);
    release_idx(3'd0);
    check("t5_valid_legal", 32'(entry_valid_o), 32'h00);
    check("t5_err_sticky", 32'(err_o), 32'd1);

    // 6: async reset mid-burst
    pulse_reset();
    check("t6_err_clr0", 32'(err_o), 32'd0);
    write(32'h60, 3'd0, "t6_wr0");
    write(32'h61, 3'd1, "t6_wr1");
    free_valid_i = 1'b1;
    free_ptr_i   = 3'd4;
    write(32'h62, 3'd2, "t6_wr2");
    free_valid_i = 1'b0;
    check("t6_count_pre", 32'(count_o), 32'd3);
    check("t6_err_pre", 32'(err_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_valid_async", 32'(entry_valid_o), 32'h00);
    check("t6_count_async", 32'(count_o), 32'd0);
    check("t6_err_async", 32'(err_o), 32'd0);
    #1;
    rst_i = 1'b0;
    cyc();
    write(32'h70, 3'd0, "t6_wr_after");
    check("t6_count_post", 32'(count_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
